// File: rtl/serial_chain_pkg.sv
// Shared definitions for the serial pattern-detector chain: feeder state
// encodings, the default idle line level and a width helper.
package serial_chain_pkg;

  typedef enum logic {
    FEED_IDLE  = 1'b0,
    FEED_SHIFT = 1'b1
  } feed_state_e;

  // Idle fill level; the detector benches assume the same value.
  localparam logic FEED_IDLE_LEVEL = 1'b0;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sbf_shift_reg.sv
// Loadable shift register for the feeder. The first bit of a loaded word is
// exposed combinationally; the register keeps only the bits still to be sent.
module sbf_shift_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             first_bit_c_o,
  output logic             head_bit_c_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  assign first_bit_c_o = MSB_FIRST ? data_i[WIDTH-1] : data_i[0];
  assign head_bit_c_o  = MSB_FIRST ? sr_q[WIDTH-1]   : sr_q[0];

  // On load the first bit goes straight to the output stage, so store the rest.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = MSB_FIRST ? (data_i << 1) : (data_i >> 1);
    end else if (shift_i) begin
      sr_d = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end for the pattern-detector chain: accepts words on
// a valid/ready handshake and streams one bit per clock with no inter-word gap.
module serial_bit_feeder
  import serial_chain_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter logic        IDLE_LEVEL = FEED_IDLE_LEVEL,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy,
  output logic [CNT_W-1:0] word_count
);

  localparam int unsigned BC_W = (WIDTH > 1) ? clog2(WIDTH) : 1;
  localparam logic [BC_W-1:0] LAST_IDX = BC_W'(WIDTH - 1);

  feed_state_e      state_q, state_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             last_bit_q, last_bit_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic at_last_c;
  logic accept_c;
  logic load_c;
  logic shift_c;
  logic first_bit_c;
  logic head_bit_c;

  sbf_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk           (clk),
    .reset         (reset),
    .load_i        (load_c),
    .shift_i       (shift_c),
    .data_i        (in_data),
    .first_bit_c_o (first_bit_c),
    .head_bit_c_o  (head_bit_c)
  );

  assign at_last_c = (state_q == FEED_SHIFT) && (bit_cnt_q == LAST_IDX);
  assign in_ready  = ~reset & ((state_q == FEED_IDLE) | at_last_c);
  assign accept_c  = in_valid & in_ready;

  // bit_cnt_q is the index of the bit currently on bit_out.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    bit_out_d   = IDLE_LEVEL;
    bit_valid_d = 1'b0;
    last_bit_d  = 1'b0;
    word_cnt_d  = word_cnt_q;
    load_c      = 1'b0;
    shift_c     = 1'b0;

    if (at_last_c) begin
      word_cnt_d = CNT_W'(word_cnt_q + 1'b1);
    end

    if (accept_c) begin
      state_d     = FEED_SHIFT;
      bit_cnt_d   = '0;
      bit_out_d   = first_bit_c;
      bit_valid_d = 1'b1;
      last_bit_d  = (WIDTH == 1);
      load_c      = 1'b1;
    end else if ((state_q == FEED_SHIFT) && !at_last_c) begin
      bit_cnt_d   = BC_W'(bit_cnt_q + 1'b1);
      bit_out_d   = head_bit_c;
      bit_valid_d = 1'b1;
      last_bit_d  = (BC_W'(bit_cnt_q + 1'b1) == LAST_IDX);
      shift_c     = 1'b1;
    end else begin
      state_d = FEED_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FEED_IDLE;
      bit_cnt_q   <= '0;
      bit_out_q   <= IDLE_LEVEL;
      bit_valid_q <= 1'b0;
      last_bit_q  <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      last_bit_q  <= last_bit_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign last_bit   = last_bit_q;
  assign busy       = bit_valid_q;
  assign word_count = word_cnt_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: a per-cycle vector table for the
// default configuration plus short sequences for LSB-first/wrap and WIDTH=1.
module tb_serial_bit_feeder;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  data;
    logic        rdy;
    logic        bo;
    logic        bv;
    logic        last;
    logic [15:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // DUT 1: defaults (WIDTH=8, MSB first, idle 0, CNT_W=16)
  logic        r1 = 1'b1;
  logic        v1 = 1'b0;
  logic [7:0]  d1 = '0;
  logic        rdy1, bo1, bv1, last1, busy1;
  logic [15:0] cnt1;

  serial_bit_feeder u_dut1 (
    .clk(clk), .reset(r1), .in_data(d1), .in_valid(v1), .in_ready(rdy1),
    .bit_out(bo1), .bit_valid(bv1), .last_bit(last1), .busy(busy1), .word_count(cnt1)
  );

  // DUT 2: WIDTH=4, LSB first, idle level 1, 2-bit counter
  logic        r2 = 1'b1;
  logic        v2 = 1'b0;
  logic [3:0]  d2 = '0;
  logic        rdy2, bo2, bv2, last2, busy2;
  logic [1:0]  cnt2;

  serial_bit_feeder #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(r2), .in_data(d2), .in_valid(v2), .in_ready(rdy2),
    .bit_out(bo2), .bit_valid(bv2), .last_bit(last2), .busy(busy2), .word_count(cnt2)
  );

  // DUT 3: WIDTH=1
  logic        r3 = 1'b1;
  logic        v3 = 1'b0;
  logic [0:0]  d3 = '0;
  logic        rdy3, bo3, bv3, last3, busy3;
  logic [3:0]  cnt3;

  serial_bit_feeder #(.WIDTH(1), .CNT_W(4)) u_dut3 (
    .clk(clk), .reset(r3), .in_data(d3), .in_valid(v3), .in_ready(rdy3),
    .bit_out(bo3), .bit_valid(bv3), .last_bit(last3), .busy(busy3), .word_count(cnt3)
  );

  vec_t vecs[$];

  task automatic add(input logic rst, input logic vld, input logic [7:0] data,
                     input logic rdy, input logic bo, input logic bv,
                     input logic last, input logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.vld = vld; v.data = data; v.rdy = rdy;
    v.bo = bo; v.bv = bv; v.last = last; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // Eight streaming cycles of one word; bits is the expected bit order, MSB sent first.
  task automatic add_word(input logic [7:0] bits, input logic vld, input logic [7:0] data,
                          input logic [15:0] cnt);
    for (int i = 0; i < 8; i++) begin
      add(1'b0, vld, data, (i == 7), bits[7-i], 1'b1, (i == 7), cnt);
    end
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    logic [0:3] pat6;
    logic [1:0] cnt6 [5];
    pat6 = 4'b1011;
    cnt6 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset with in_valid high, then idle
    repeat (3) add(1'b1, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    // Single word B0
    add(1'b0, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    add_word(8'b1011_0000, 1'b0, 8'h00, 16'd0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
    // Back-to-back A5 then 0B
    add(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
    add_word(8'b1010_0101, 1'b1, 8'h0B, 16'd1);
    add_word(8'b0000_1011, 1'b0, 8'h00, 16'd2);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3);
    // Backpressure: FF offered throughout 3C, taken only at its last bit
    add(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3);
    add_word(8'b0011_1100, 1'b1, 8'hFF, 16'd3);
    add_word(8'b1111_1111, 1'b0, 8'h00, 16'd4);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5);
    // Reset during bit 3 of B0
    add(1'b0, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'd5);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'd5);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'd5);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'd5);
    add(1'b0, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);

    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      r1 = vecs[i].rst;
      v1 = vecs[i].vld;
      d1 = vecs[i].data;
      #1;
      check("in_ready",   i, 32'(rdy1),  32'(vecs[i].rdy));
      check("bit_out",    i, 32'(bo1),   32'(vecs[i].bo));
      check("bit_valid",  i, 32'(bv1),   32'(vecs[i].bv));
      check("last_bit",   i, 32'(last1), 32'(vecs[i].last));
      check("busy",       i, 32'(busy1), 32'(vecs[i].bv));
      check("word_count", i, 32'(cnt1),  32'(vecs[i].cnt));
    end

    // LSB-first WIDTH=4: five back-to-back 4'b1101 words, counter wraps
    @(negedge clk);
    r2 = 1'b0; v2 = 1'b1; d2 = 4'b1101;
    #1;
    check("w4_idle_ready", 0, 32'(rdy2), 32'd1);
    check("w4_idle_bit",   0, 32'(bo2),  32'd1);
    check("w4_idle_valid", 0, 32'(bv2),  32'd0);
    for (int w = 0; w < 5; w++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (w == 4 && k == 3) v2 = 1'b0;
        #1;
        check("w4_bit",   w * 4 + k, 32'(bo2),   32'(pat6[k]));
        check("w4_valid", w * 4 + k, 32'(bv2),   32'd1);
        check("w4_last",  w * 4 + k, 32'(last2), 32'(k == 3));
        check("w4_ready", w * 4 + k, 32'(rdy2),  32'(k == 3));
        if (k == 0) check("w4_count", w, 32'(cnt2), 32'(cnt6[w]));
      end
    end
    @(negedge clk);
    #1;
    check("w4_end_valid", 0, 32'(bv2),   32'd0);
    check("w4_end_bit",   0, 32'(bo2),   32'd1);
    check("w4_end_last",  0, 32'(last2), 32'd0);
    check("w4_end_count", 0, 32'(cnt2),  32'd1);

    // WIDTH=1: always ready, every bit is a last bit
    @(negedge clk);
    r3 = 1'b0; v3 = 1'b1; d3 = 1'b1;
    #1;
    check("w1_ready", 0, 32'(rdy3), 32'd1);
    @(negedge clk);
    d3 = 1'b0;
    #1;
    check("w1_bit",   1, 32'(bo3),   32'd1);
    check("w1_last",  1, 32'(last3), 32'd1);
    check("w1_ready", 1, 32'(rdy3),  32'd1);
    @(negedge clk);
    d3 = 1'b1;
    #1;
    check("w1_bit",   2, 32'(bo3),   32'd0);
    check("w1_valid", 2, 32'(bv3),   32'd1);
    check("w1_last",  2, 32'(last3), 32'd1);
    check("w1_count", 2, 32'(cnt3),  32'd1);
    @(negedge clk);
    v3 = 1'b0;
    #1;
    check("w1_bit",   3, 32'(bo3),   32'd1);
    check("w1_count", 3, 32'(cnt3),  32'd2);
    @(negedge clk);
    #1;
    check("w1_valid", 4, 32'(bv3),   32'd0);
    check("w1_last",  4, 32'(last3), 32'd0);
    check("w1_ready", 4, 32'(rdy3),  32'd1);
    check("w1_count", 4, 32'(cnt3),  32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
